// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decoder until accepted, follows branch/jump redirects and
// parks in a terminal fault state on a misaligned redirect target.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic        MemReadRequest,
  output logic [31:0] MemAddress,
  input  logic        MemReadValid,
  input  logic [31:0] MemReadData,
  output logic [31:0] Instruction,
  output logic [31:0] InstructionPC,
  output logic        InstructionValid,
  input  logic        InstructionAccept,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        FetchFault,
  output logic [31:0] FetchCount
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    DRAIN   = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  // Set when a misaligned redirect arrives while a request is still in flight;
  // the outstanding response must be drained before the unit parks in FAULT.
  logic        fault_pend_r;

  logic        redirect_bad_s;
  logic        redirect_ok_s;
  logic [31:0] pc_plus4_s;

  assign redirect_bad_s = RedirectValid && (RedirectTarget[1:0] != 2'b00);
  assign redirect_ok_s  = RedirectValid && (RedirectTarget[1:0] == 2'b00);
  assign pc_plus4_s     = pc_r + 32'd4;

  // Fetch FSM: state, PC and all outputs are registered here.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r          <= IDLE;
      pc_r             <= RESET_VECTOR;
      fault_pend_r     <= 1'b0;
      MemReadRequest   <= 1'b0;
      MemAddress       <= RESET_VECTOR;
      Instruction      <= 32'h0000_0000;
      InstructionPC    <= 32'h0000_0000;
      InstructionValid <= 1'b0;
      FetchFault       <= 1'b0;
      FetchCount       <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          state_r        <= REQUEST;
          MemReadRequest <= 1'b1;
          MemAddress     <= pc_r;
        end

        REQUEST: begin
          if (redirect_bad_s) begin
            FetchFault       <= 1'b1;
            InstructionValid <= 1'b0;
            if (MemReadValid) begin
              MemReadRequest <= 1'b0;
              state_r        <= FAULT;
            end else begin
              fault_pend_r   <= 1'b1;
              state_r        <= DRAIN;
            end
          end else if (redirect_ok_s) begin
            pc_r <= RedirectTarget;
            if (MemReadValid) begin
              // Response arrived with the redirect: drop it and refetch at once.
              MemAddress <= RedirectTarget;
            end else begin
              // Keep the old request on the bus until its response shows up.
              state_r    <= DRAIN;
            end
          end else if (MemReadValid) begin
            Instruction      <= MemReadData;
            InstructionPC    <= pc_r;
            InstructionValid <= 1'b1;
            MemReadRequest   <= 1'b0;
            state_r          <= HOLD;
          end
        end

        DRAIN: begin
          if (!fault_pend_r) begin
            if (redirect_bad_s) begin
              FetchFault   <= 1'b1;
              fault_pend_r <= 1'b1;
            end else if (redirect_ok_s) begin
              pc_r <= RedirectTarget;
            end
          end
          if (MemReadValid) begin
            if (fault_pend_r || redirect_bad_s) begin
              MemReadRequest <= 1'b0;
              state_r        <= FAULT;
            end else begin
              MemAddress <= redirect_ok_s ? RedirectTarget : pc_r;
              state_r    <= REQUEST;
            end
          end
        end

        HOLD: begin
          // An accept counts even when a redirect lands in the same cycle.
          if (InstructionAccept) begin
            FetchCount <= FetchCount + 32'd1;
          end
          if (redirect_bad_s) begin
            FetchFault       <= 1'b1;
            InstructionValid <= 1'b0;
            state_r          <= FAULT;
          end else if (redirect_ok_s) begin
            pc_r             <= RedirectTarget;
            InstructionValid <= 1'b0;
            MemReadRequest   <= 1'b1;
            MemAddress       <= RedirectTarget;
            state_r          <= REQUEST;
          end else if (InstructionAccept) begin
            pc_r             <= pc_plus4_s;
            InstructionValid <= 1'b0;
            MemReadRequest   <= 1'b1;
            MemAddress       <= pc_plus4_s;
            state_r          <= REQUEST;
          end
        end

        FAULT: begin
          MemReadRequest   <= 1'b0;
          InstructionValid <= 1'b0;
        end

        default: begin
          MemReadRequest <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 SHALL have port Clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ResetN, input, 1, meaning reset; asynchronous, active-low.
REQ-004 SHALL have port MemReadRequest, output, 1, meaning an instruction-memory read request.
REQ-005 SHALL have port MemAddress, output, 32, meaning the word-aligned fetch address.
REQ-006 SHALL have port MemReadValid, input, 1, meaning MemReadData is valid this cycle.
REQ-007 SHALL have port MemReadData, input, 32, meaning the fetched instruction word.
REQ-008 SHALL have port Instruction, output, 32, meaning the held instruction word driven to the instruction decoder.
REQ-009 SHALL have port InstructionPC, output, 32, meaning the address of Instruction.
REQ-010 SHALL have port InstructionValid, output, 1, meaning Instruction and InstructionPC are valid.
REQ-011 SHALL have port InstructionAccept, input, 1, meaning downstream consumes Instruction this cycle.
REQ-012 SHALL have port RedirectValid, input, 1, meaning a taken branch or jump.
REQ-013 SHALL have port RedirectTarget, input, 32, meaning the new PC for a redirect.
REQ-014 SHALL have port FetchFault, output, 1, meaning a misaligned redirect target was received; sticky.
REQ-015 SHALL have port FetchCount, output, 32, meaning the number of accepted instructions, modulo 2^32.

Function
REQ-016 SHALL implement states IDLE, REQUEST, DRAIN, HOLD and FAULT.
REQ-017 MemReadRequest SHALL be 1 exactly in REQUEST and DRAIN; MemAddress SHALL equal PC in REQUEST and the latched old address in DRAIN; both SHALL be stable until MemReadValid.
REQ-018 IDLE -> REQUEST SHALL occur unconditionally on the first clock edge after ResetN deasserts.
REQ-019 In REQUEST with MemReadValid=1 and RedirectValid=0: Instruction<=MemReadData; InstructionPC<=PC; InstructionValid<=1; go to HOLD.
REQ-020 In HOLD with InstructionAccept=1 and RedirectValid=0: PC<=PC+4 (32-bit wrap, 0xFFFFFFFC->0x00000000); InstructionValid<=0; FetchCount+=1; go to REQUEST.
REQ-021 In HOLD without accept or redirect, all outputs SHALL hold; memory latency SHALL be unbounded (any number of cycles ≥1).
REQ-022 Redirect in HOLD SHALL set PC<=RedirectTarget, InstructionValid<=0 and go to REQUEST; a simultaneous accept SHALL still increment FetchCount, with the redirect winning for PC.
REQ-023 Redirect in REQUEST with MemReadValid=0 SHALL set PC<=RedirectTarget and go to DRAIN, keeping the request at the old address.
REQ-024 Redirect in REQUEST with MemReadValid=1 SHALL discard the data, set PC<=RedirectTarget and go to REQUEST.
REQ-025 DRAIN with MemReadValid=1 SHALL discard the data and go to REQUEST; a further redirect in DRAIN SHALL only update PC.
REQ-026 Redirect with RedirectTarget[1:0]!=0 in any state SHALL set FetchFault<=1, InstructionValid<=0 and go to FAULT (after draining any outstanding request).
REQ-027 FAULT SHALL be terminal until reset, with MemReadRequest=0 and all inputs ignored.
REQ-028 Best case, SHALL sustain one instruction per 2 cycles with 1-cycle memory and immediate accept.
REQ-029 MemReadValid outside REQUEST and DRAIN SHALL be ignored.

Reset
REQ-030 ResetN=0 SHALL immediately force state IDLE, PC=RESET_VECTOR, Instruction=0, InstructionPC=0, InstructionValid=0, MemReadRequest=0, MemAddress=RESET_VECTOR, FetchFault=0 and FetchCount=0, regardless of the clock.
REQ-031 Reset during REQUEST or DRAIN SHALL abandon the outstanding request; a late MemReadValid SHALL be ignored by REQ-029.

Verification
REQ-032 Reset release, 1-cycle memory returning 0x00000013, accept held 1 -> addresses 0x0, 0x4, 0x8 on alternate cycles; FetchCount=3 after the third accept.
REQ-033 3-cycle memory latency, accept held 0 for 5 cycles -> MemAddress stable during the wait; Instruction and InstructionPC hold for all 5 cycles.
REQ-034 Redirect to 0x100 during REQUEST at 0x8 with the response 2 cycles later -> DRAIN; the 0x8 data is never valid; the next request goes to 0x100.
REQ-035 Redirect to 0x200 with accept in HOLD -> FetchCount increments; the next request goes to 0x200, not PC+4.
REQ-036 Redirect to 0x102 -> FetchFault=1; MemReadRequest=0 thereafter; recovery only via ResetN.
REQ-037 PC=0xFFFFFFFC accepted -> next MemAddress=0x00000000; async ResetN pulse mid-REQUEST -> all outputs immediately take their REQ-030 values.
